bus_write_sequencer: RTL and testbench
======================================

BUS_WRITE_SEQUENCER -- requirements
Module: bus_write_sequencer

Interface
REQ-001 SHALL have parameter QUAL_CYCLES, default 2, meaning consecutive clk edges the access condition must hold before acceptance (legal 1..7).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2, meaning extra clk edges waited after qualification before address/data capture (legal 1..7).
REQ-003 SHALL have port clk  input  1  destination clock; all logic is clocked on the rising edge.
REQ-004 SHALL have port _reset_in  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port base_decode  input  1  already-synchronized base address strobe, active-high.
REQ-006 SHALL have port _ds  input  1  already-synchronized data strobe, active-low.
REQ-007 SHALL have port adr_l  input  [11:8]  already-synchronized register address.
REQ-008 SHALL have port data  input  [7:0]  already-synchronized write data.
REQ-009 SHALL have port wr_stb  output  1  one-cycle register write pulse.
REQ-010 SHALL have port wr_adr  output  [3:0]  captured register address, valid while wr_stb=1 and held afterwards.
REQ-011 SHALL have port wr_data  output  [7:0]  captured write data, valid while wr_stb=1 and held afterwards.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port abort  output  1  one-cycle pulse when a started access is dropped before capture.
REQ-014 SHALL have port acc_cnt  output  [7:0]  count of completed writes.

Function
REQ-015 SHALL define "cond" as base_decode=1 AND _ds=0, sampled at each rising clk edge.
REQ-016 SHALL implement states IDLE, QUAL, SETTLE, WAIT_END; all outputs registered.
REQ-017 IDLE: cond sampled -> QUAL with qualification count=1; otherwise stay.
REQ-018 QUAL: cond sampled -> count+1; on the edge where count reaches QUAL_CYCLES -> SETTLE with settle count=0; with QUAL_CYCLES=1 IDLE goes directly to SETTLE.
REQ-019 QUAL: cond not sampled -> IDLE, abort=1 for one cycle.
REQ-020 SETTLE: _ds=0 sampled -> settle count+1; base_decode is ignored in this state.
REQ-021 SETTLE: _ds=1 sampled before the count completes -> IDLE, abort=1 for one cycle, no capture.
REQ-022 SETTLE: on the edge where the settle count reaches SETTLE_CYCLES -> capture adr_l into wr_adr and data into wr_data, assert wr_stb for exactly one cycle, increment acc_cnt, go to WAIT_END.
REQ-023 Latency: wr_stb SHALL be high in the cycle following the (QUAL_CYCLES+SETTLE_CYCLES)th rising edge, counting the first edge at which cond is sampled as edge 1.
REQ-024 WAIT_END: stay while _ds=0; _ds=1 sampled -> IDLE; base_decode, adr_l and data changes are ignored; no second wr_stb is issued.
REQ-025 acc_cnt SHALL wrap from 255 to 0 with no flag.
REQ-026 wr_stb and abort SHALL never be high in the same cycle.
REQ-027 wr_adr and wr_data SHALL change only on the capture edge.
REQ-028 A new access SHALL require a pass through IDLE, i.e. _ds must be seen high for at least one edge between writes.

Reset
REQ-029 _reset_in=0 SHALL immediately and asynchronously force: state=IDLE, wr_stb=0, abort=0, busy=0, wr_adr=0, wr_data=0, acc_cnt=0, and all internal counters=0.
REQ-030 Reset asserted mid-access SHALL discard the access with no wr_stb and no abort; after release the block SHALL wait in IDLE for cond.

Verification
REQ-031 QUAL=2, SETTLE=2; base_decode=1, _ds=0, adr_l=4'hA, data=8'h5C held -> wr_stb is high for one cycle after edge 4, wr_adr=A, wr_data=5C, acc_cnt 0->1.
REQ-032 _ds low for 1 edge only during QUAL -> abort pulse, no wr_stb, acc_cnt unchanged, state returns to IDLE.
REQ-033 _ds released in SETTLE after 1 settle edge -> abort pulse, wr_adr/wr_data keep their previous values.
REQ-034 _ds held low for 20 cycles after capture while data changes -> exactly one wr_stb, wr_data unchanged, busy=1 until _ds=1 is sampled.
REQ-035 256 back-to-back complete writes -> acc_cnt returns to 8'h00.
REQ-036 _reset_in pulsed low during SETTLE -> all outputs are 0 immediately, no wr_stb follows; the next full access completes normally.

Source files
------------

// File: rtl/bus_write_sequencer.sv
// Qualifies a bus write strobe, waits for the data lines to settle, then captures
// address and data and issues a single write pulse. All outputs are registered.
module bus_write_sequencer #(
   parameter int QUAL_CYCLES   = 2,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        _reset_in,
   input  logic        base_decode,
   input  logic        _ds,
   input  logic [11:8] adr_l,
   input  logic [7:0]  data,
   output logic        wr_stb,
   output logic [3:0]  wr_adr,
   output logic [7:0]  wr_data,
   output logic        busy,
   output logic        abort,
   output logic [7:0]  acc_cnt
);

   typedef enum logic [1:0] {IDLE, QUAL, SETTLE, WAIT_END} state_t;

   localparam logic [2:0] QUAL_N   = 3'(QUAL_CYCLES);
   localparam logic [2:0] SETTLE_N = 3'(SETTLE_CYCLES);

   state_t     state, state_nxt;
   logic [2:0] qual_cnt, qual_cnt_nxt;
   logic [2:0] settle_cnt, settle_cnt_nxt;
   logic       stb_nxt, abort_nxt;
   logic       cond;

   assign cond = base_decode & ~_ds;

   always_comb begin
      state_nxt      = state;
      qual_cnt_nxt   = qual_cnt;
      settle_cnt_nxt = settle_cnt;
      stb_nxt        = 1'b0;
      abort_nxt      = 1'b0;
      case (state)
         IDLE: begin
            if (cond) begin
               qual_cnt_nxt   = 3'd1;
               settle_cnt_nxt = 3'd0;
               state_nxt      = (QUAL_N == 3'd1) ? SETTLE : QUAL;
            end
         end
         QUAL: begin
            if (cond) begin
               qual_cnt_nxt = qual_cnt + 3'd1;
               if (qual_cnt + 3'd1 == QUAL_N) begin
                  state_nxt      = SETTLE;
                  settle_cnt_nxt = 3'd0;
               end
            end else begin
               state_nxt    = IDLE;
               qual_cnt_nxt = 3'd0;
               abort_nxt    = 1'b1;
            end
         end
         SETTLE: begin
            // Only the data strobe matters here; base_decode may already be moving.
            if (!_ds) begin
               settle_cnt_nxt = settle_cnt + 3'd1;
               if (settle_cnt + 3'd1 == SETTLE_N) begin
                  state_nxt = WAIT_END;
                  stb_nxt   = 1'b1;
               end
            end else begin
               state_nxt      = IDLE;
               qual_cnt_nxt   = 3'd0;
               settle_cnt_nxt = 3'd0;
               abort_nxt      = 1'b1;
            end
         end
         WAIT_END: begin
            if (_ds) begin
               state_nxt      = IDLE;
               qual_cnt_nxt   = 3'd0;
               settle_cnt_nxt = 3'd0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge _reset_in) begin
      if (!_reset_in) begin
         state      <= IDLE;
         qual_cnt   <= 3'd0;
         settle_cnt <= 3'd0;
         wr_stb     <= 1'b0;
         abort      <= 1'b0;
         busy       <= 1'b0;
         wr_adr     <= 4'd0;
         wr_data    <= 8'd0;
         acc_cnt    <= 8'd0;
      end else begin
         state      <= state_nxt;
         qual_cnt   <= qual_cnt_nxt;
         settle_cnt <= settle_cnt_nxt;
         wr_stb     <= stb_nxt;
         abort      <= abort_nxt;
         busy       <= (state_nxt != IDLE);
         if (stb_nxt) begin
            wr_adr  <= adr_l;
            wr_data <= data;
            acc_cnt <= acc_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_bus_write_sequencer.sv
// Directed and random stimulus for bus_write_sequencer against a windowed access model.
module tb_bus_write_sequencer;

   localparam int Q = 2;
   localparam int S = 2;

   logic        clk = 1'b0;
   logic        reset_in = 1'b0;
   logic        base_decode = 1'b0;
   logic        ds = 1'b1;
   logic [11:8] adr_l = 4'h0;
   logic [7:0]  data = 8'h00;
   logic        wr_stb, busy, abort;
   logic [3:0]  wr_adr;
   logic [7:0]  wr_data, acc_cnt;

   int tests = 0;
   int fails = 0;

   // Reference: position inside the Q+S edge window of the current access.
   int         pos = 0;
   bit         waiting = 0;
   logic       m_stb = 0, m_abort = 0;
   logic [3:0] m_adr = 0;
   logic [7:0] m_data = 0, m_cnt = 0;

   bus_write_sequencer #(.QUAL_CYCLES(Q), .SETTLE_CYCLES(S)) dut (
      .clk(clk), ._reset_in(reset_in), .base_decode(base_decode), ._ds(ds),
      .adr_l(adr_l), .data(data), .wr_stb(wr_stb), .wr_adr(wr_adr),
      .wr_data(wr_data), .busy(busy), .abort(abort), .acc_cnt(acc_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".wr_stb"},  32'(wr_stb),  32'(m_stb));
      chk({tag, ".abort"},   32'(abort),   32'(m_abort));
      chk({tag, ".busy"},    32'(busy),    32'(pos != 0 || waiting));
      chk({tag, ".wr_adr"},  32'(wr_adr),  32'(m_adr));
      chk({tag, ".wr_data"}, 32'(wr_data), 32'(m_data));
      chk({tag, ".acc_cnt"}, 32'(acc_cnt), 32'(m_cnt));
      chk({tag, ".excl"},    32'(wr_stb & abort), 32'd0);
   endtask

   task automatic model_edge();
      bit c;
      bit ok;
      c = base_decode && !ds;
      m_stb = 0;
      m_abort = 0;
      if (waiting) begin
         if (ds) waiting = 0;
      end else if (pos == 0) begin
         if (c) pos = 1;
      end else begin
         pos++;
         ok = (pos <= Q) ? c : !ds;
         if (!ok) begin
            m_abort = 1;
            pos = 0;
         end else if (pos == Q + S) begin
            m_stb = 1;
            m_adr = adr_l;
            m_data = data;
            m_cnt = m_cnt + 8'd1;
            waiting = 1;
            pos = 0;
         end
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic model_reset();
      pos = 0; waiting = 0; m_stb = 0; m_abort = 0;
      m_adr = 0; m_data = 0; m_cnt = 0;
   endtask

   // Asserts reset away from any clock edge and checks outputs clear immediately.
   task automatic do_reset(input string tag);
      #2;
      reset_in = 1'b0;
      model_reset();
      #1;
      check_all({tag, ".async"});
      @(negedge clk);
      @(negedge clk);
      check_all({tag, ".held"});
      reset_in = 1'b1;
   endtask

   task automatic full_write(input string tag, input logic [3:0] a, input logic [7:0] d);
      base_decode = 1; ds = 0; adr_l = a; data = d;
      for (int i = 0; i < Q + S; i++) tick(tag);
      ds = 1; base_decode = 0;
      tick({tag, ".end"});
   endtask

   int stb_seen;

   initial begin
      // reset state
      #3;
      model_reset();
      check_all("por");
      @(negedge clk);
      reset_in = 1'b1;

      // basic write: pulse after edge Q+S with captured values
      base_decode = 1; ds = 0; adr_l = 4'hA; data = 8'h5C;
      for (int i = 1; i < Q + S; i++) begin
         tick("basic");
         chk("basic.no_stb_early", 32'(wr_stb), 32'd0);
      end
      tick("basic.cap");
      chk("basic.stb", 32'(wr_stb), 32'd1);
      chk("basic.adr", 32'(wr_adr), 32'hA);
      chk("basic.data", 32'(wr_data), 32'h5C);
      chk("basic.cnt", 32'(acc_cnt), 32'd1);
      tick("basic.after");
      chk("basic.stb_once", 32'(wr_stb), 32'd0);
      ds = 1;
      tick("basic.release");
      chk("basic.idle", 32'(busy), 32'd0);

      // strobe for one edge during qualification
      base_decode = 1; ds = 0; adr_l = 4'h3; data = 8'h11;
      tick("qabort.start");
      ds = 1;
      tick("qabort.drop");
      chk("qabort.abort", 32'(abort), 32'd1);
      chk("qabort.cnt", 32'(acc_cnt), 32'd1);
      tick("qabort.idle");

      // strobe released after one settle edge
      base_decode = 1; ds = 0; adr_l = 4'h6; data = 8'hE7;
      for (int i = 0; i < Q + 1; i++) tick("sabort.run");
      ds = 1;
      tick("sabort.drop");
      chk("sabort.abort", 32'(abort), 32'd1);
      chk("sabort.adr_kept", 32'(wr_adr), 32'hA);
      chk("sabort.data_kept", 32'(wr_data), 32'h5C);
      tick("sabort.idle");

      // long strobe after capture with data moving
      base_decode = 1; ds = 0; adr_l = 4'h9; data = 8'h42;
      for (int i = 0; i < Q + S; i++) tick("hold.run");
      stb_seen = 0;
      for (int i = 0; i < 20; i++) begin
         data = 8'($urandom); adr_l = 4'($urandom); base_decode = 1'($urandom);
         tick("hold.wait");
         stb_seen += int'(wr_stb);
         chk("hold.busy", 32'(busy), 32'd1);
         chk("hold.data", 32'(wr_data), 32'h42);
      end
      chk("hold.no_second_stb", 32'(stb_seen), 32'd0);
      ds = 1;
      tick("hold.release");
      chk("hold.idle", 32'(busy), 32'd0);

      // reset in the settle window discards the access
      base_decode = 1; ds = 0; adr_l = 4'h2; data = 8'h77;
      for (int i = 0; i < Q + 1; i++) tick("rst.run");
      do_reset("rst");
      for (int i = 0; i < 3; i++) begin
         tick("rst.after");
         chk("rst.no_stb", 32'(wr_stb), 32'd0);
      end
      ds = 1; base_decode = 0;
      tick("rst.idle");
      full_write("rst.next", 4'hB, 8'hC3);
      chk("rst.next_cnt", 32'(acc_cnt), 32'd1);

      // 256 writes wrap the counter
      do_reset("wrap.rst");
      for (int i = 0; i < 256; i++) full_write("wrap", 4'(i), 8'(i * 7));
      chk("wrap.cnt", 32'(acc_cnt), 32'd0);

      // random traffic, occasional reset
      for (int i = 0; i < 3000; i++) begin
         base_decode = ($urandom_range(0, 9) < 8);
         ds = ($urandom_range(0, 9) < 3);
         adr_l = 4'($urandom);
         data = 8'($urandom);
         if ($urandom_range(0, 299) == 0) do_reset("rnd.rst");
         else tick("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
